// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (inst) and load/store (data) requesters onto one shared
// memory port with at most one transaction outstanding.
module mem_port_arbiter #(
  parameter int DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic L_DATA_PRIO = (DATA_PRIO != 0);

  state_t      r_state;
  logic        r_owner;   // 1 = data requester owns the port
  logic        r_last;    // 1 = data was granted most recently
  logic        r_busy;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_idle;
  logic        w_gnt_data;
  logic        w_req;
  logic        w_owner;
  logic        w_wr;
  logic [1:0]  w_size;
  logic [3:0]  w_wstrb;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  assign w_idle     = (r_state == S_IDLE);
  // Data wins when alone, under fixed priority, or when inst was last granted.
  assign w_gnt_data = data_req & (~inst_req | L_DATA_PRIO | ~r_last);
  assign w_req      = resetn & (w_idle ? (inst_req | data_req) : (r_state == S_HOLD));
  assign w_owner    = w_idle ? w_gnt_data : r_owner;

  always_comb begin
    w_wr    = r_wr;
    w_size  = r_size;
    w_wstrb = r_wstrb;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    if (w_idle) begin
      if (w_gnt_data) begin
        w_wr    = data_wr;
        w_size  = data_size;
        w_wstrb = data_wstrb;
        w_addr  = data_addr;
        w_wdata = data_wdata;
      end else begin
        w_wr    = 1'b0;
        w_size  = 2'd2;
        w_wstrb = 4'd0;
        w_addr  = inst_addr;
        w_wdata = 32'd0;
      end
    end
  end

  assign mem_req      = w_req;
  assign mem_wr       = w_wr;
  assign mem_size     = w_size;
  assign mem_wstrb    = w_wstrb;
  assign mem_addr     = w_addr;
  assign mem_wdata    = w_wdata;

  assign inst_addr_ok = mem_addr_ok & w_req & ~w_owner;
  assign data_addr_ok = mem_addr_ok & w_req &  w_owner;
  assign inst_data_ok = mem_data_ok & (r_state == S_WAIT) & ~r_owner;
  assign data_data_ok = mem_data_ok & (r_state == S_WAIT) &  r_owner;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = r_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_owner <= w_gnt_data;
            r_wr    <= w_wr;
            r_size  <= w_size;
            r_wstrb <= w_wstrb;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_busy  <= 1'b1;
            if (mem_addr_ok) begin
              r_state <= S_WAIT;
              r_last  <= w_gnt_data;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (mem_addr_ok) begin
            r_state <= S_WAIT;
            r_last  <= r_owner;
          end
        end
        S_WAIT: begin
          if (mem_data_ok) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: both DATA_PRIO variants share stimulus; a transaction-level
// model queues expected strobes, and a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  // index 0: DATA_PRIO=0 (round robin), index 1: DATA_PRIO=1
  logic        o_iaok[2], o_idok[2], o_daok[2], o_ddok[2];
  logic        o_mreq[2], o_mwr[2], o_busy[2];
  logic [1:0]  o_msize[2];
  logic [3:0]  o_mwstrb[2];
  logic [31:0] o_maddr[2], o_mwdata[2], o_irdata[2], o_drdata[2];

  mem_port_arbiter #(.DATA_PRIO(0)) u_rr (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(o_iaok[0]), .inst_data_ok(o_idok[0]), .inst_rdata(o_irdata[0]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(o_daok[0]), .data_data_ok(o_ddok[0]), .data_rdata(o_drdata[0]),
    .mem_req(o_mreq[0]), .mem_wr(o_mwr[0]), .mem_size(o_msize[0]),
    .mem_wstrb(o_mwstrb[0]), .mem_addr(o_maddr[0]), .mem_wdata(o_mwdata[0]),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(o_busy[0])
  );

  mem_port_arbiter #(.DATA_PRIO(1)) u_dp (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(o_iaok[1]), .inst_data_ok(o_idok[1]), .inst_rdata(o_irdata[1]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(o_daok[1]), .data_data_ok(o_ddok[1]), .data_rdata(o_drdata[1]),
    .mem_req(o_mreq[1]), .mem_wr(o_mwr[1]), .mem_size(o_msize[1]),
    .mem_wstrb(o_mwstrb[1]), .mem_addr(o_maddr[1]), .mem_wdata(o_mwdata[1]),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(o_busy[1])
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;   // request address, or read data for data_ok events
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } ev_t;

  ev_t  q_aok[2][2][$];   // [instance][requester 0=inst 1=data]
  ev_t  q_dok[2][2][$];
  logic exp_busy[2];

  // Transaction-level model state
  int   m_out[2];         // owner of the accepted transaction, -1 none
  int   m_pend[2];        // owner of the presented-not-accepted transaction, -1 none
  ev_t  m_ptx[2];
  int   m_last[2];        // requester granted most recently

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic model_reset(input int k);
    m_out[k]  = -1;
    m_pend[k] = -1;
    m_last[k] = 0;
  endtask

  task automatic model_step(input int k);
    ev_t e;
    int  w;
    if (!resetn) begin
      model_reset(k);
      exp_busy[k] = 1'b0;
      return;
    end
    exp_busy[k] = (m_out[k] >= 0) || (m_pend[k] >= 0);
    if (m_out[k] >= 0) begin
      if (mem_data_ok) begin
        e = '{cyc, mem_rdata, 1'b0, 2'd0, 4'd0, 32'd0};
        q_dok[k][m_out[k]].push_back(e);
        m_out[k] = -1;
      end
    end else if (m_pend[k] >= 0) begin
      if (mem_addr_ok) begin
        e = m_ptx[k];
        e.cyc = cyc;
        q_aok[k][m_pend[k]].push_back(e);
        m_out[k]  = m_pend[k];
        m_last[k] = m_pend[k];
        m_pend[k] = -1;
      end
    end else if (inst_req || data_req) begin
      if (inst_req && data_req) w = (k == 1) ? 1 : ((m_last[k] == 0) ? 1 : 0);
      else                      w = data_req ? 1 : 0;
      if (w == 1) e = '{cyc, data_addr, data_wr, data_size, data_wstrb, data_wdata};
      else        e = '{cyc, inst_addr, 1'b0, 2'd2, 4'd0, 32'd0};
      if (mem_addr_ok) begin
        q_aok[k][w].push_back(e);
        m_out[k]  = w;
        m_last[k] = w;
      end else begin
        m_ptx[k]  = e;
        m_pend[k] = w;
      end
    end
  endtask

  task automatic mon_aok(input int k, input int r, input logic s);
    ev_t e;
    if (s) begin
      checks++;
      if (q_aok[k][r].size() == 0) begin
        errors++;
        $display("FAIL addr_ok_unexpected dut%0d req%0d cyc=%0d got=1 expected=0", k, r, cyc);
      end else begin
        e = q_aok[k][r].pop_front();
        if (e.cyc != cyc || o_mreq[k] !== 1'b1 || o_maddr[k] !== e.addr || o_mwr[k] !== e.wr ||
            o_msize[k] !== e.size || o_mwstrb[k] !== e.wstrb || o_mwdata[k] !== e.wdata) begin
          errors++;
          $display("FAIL addr_ok dut%0d req%0d got cyc=%0d req=%b addr=%h wr=%b size=%0d wstrb=%h wdata=%h expected cyc=%0d req=1 addr=%h wr=%b size=%0d wstrb=%h wdata=%h",
                   k, r, cyc, o_mreq[k], o_maddr[k], o_mwr[k], o_msize[k], o_mwstrb[k], o_mwdata[k],
                   e.cyc, e.addr, e.wr, e.size, e.wstrb, e.wdata);
        end
      end
    end else if (q_aok[k][r].size() > 0 && q_aok[k][r][0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL addr_ok_missing dut%0d req%0d cyc=%0d got=0 expected=1", k, r, cyc);
      void'(q_aok[k][r].pop_front());
    end
  endtask

  task automatic mon_dok(input int k, input int r, input logic s);
    ev_t         e;
    logic [31:0] rd;
    rd = (r == 1) ? o_drdata[k] : o_irdata[k];
    if (s) begin
      checks++;
      if (q_dok[k][r].size() == 0) begin
        errors++;
        $display("FAIL data_ok_unexpected dut%0d req%0d cyc=%0d got=1 expected=0", k, r, cyc);
      end else begin
        e = q_dok[k][r].pop_front();
        if (e.cyc != cyc || rd !== e.addr) begin
          errors++;
          $display("FAIL data_ok dut%0d req%0d got cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                   k, r, cyc, rd, e.cyc, e.addr);
        end
      end
    end else if (q_dok[k][r].size() > 0 && q_dok[k][r][0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL data_ok_missing dut%0d req%0d cyc=%0d got=0 expected=1", k, r, cyc);
      void'(q_dok[k][r].pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_busy[k] !== exp_busy[k]) begin
        errors++;
        $display("FAIL busy dut%0d cyc=%0d got=%b expected=%b", k, cyc, o_busy[k], exp_busy[k]);
      end
      if (!resetn) begin
        checks++;
        if (o_mreq[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_mem_req dut%0d cyc=%0d got=%b expected=0", k, cyc, o_mreq[k]);
        end
      end
      mon_aok(k, 0, o_iaok[k]);
      mon_aok(k, 1, o_daok[k]);
      mon_dok(k, 0, o_idok[k]);
      mon_dok(k, 1, o_ddok[k]);
    end
  end

  task automatic set_store(input logic [31:0] a);
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_size  = 2'd2;
    data_wstrb = 4'hF;
    data_addr  = a;
    data_wdata = 32'hDEADBEEF;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      exp_busy[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    for (int n = 1; n <= 4000; n++) begin
      @(posedge clk);
      #1;
      cyc++;
      inst_req    = ($urandom_range(0, 9) < 6);
      inst_addr   = $urandom;
      data_req    = ($urandom_range(0, 9) < 6);
      data_wr     = $urandom_range(0, 1);
      data_size   = 2'($urandom_range(0, 2));
      data_wstrb  = 4'($urandom_range(0, 15));
      data_addr   = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = $urandom_range(0, 1);
      mem_data_ok = ($urandom_range(0, 9) < 4);
      mem_rdata   = $urandom;
      if (n == 1) resetn = 1'b1;
      case (n)
        1: begin inst_req = 1'b1; inst_addr = 32'h1C000000; data_req = 1'b0;
                 mem_addr_ok = 1'b1; mem_data_ok = 1'b0; end
        2: begin inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0; end
        3: begin inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b1;
                 mem_rdata = 32'h02800000; end
        4: begin inst_req = 1'b1; set_store(32'h1000); mem_addr_ok = 1'b1; mem_data_ok = 1'b0; end
        5: begin inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b1; end
        6: begin inst_req = 1'b1; set_store(32'h1000); mem_addr_ok = 1'b0; mem_data_ok = 1'b0; end
        7, 8: begin inst_req = 1'b1; set_store(32'h2000); mem_addr_ok = 1'b0; end
        9: begin inst_req = 1'b1; set_store(32'h2000); mem_addr_ok = 1'b1; mem_data_ok = 1'b0; end
        10: begin inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; end
        11, 12, 13, 14, 15, 16, 17, 18: begin
          inst_req = 1'b1; data_req = 1'b1;
          mem_addr_ok = n[0]; mem_data_ok = ~n[0];
        end
        19: begin inst_req = 1'b1; data_req = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b0; end
        20: begin resetn = 1'b0; mem_data_ok = 1'b0; end
        21: begin resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b1; end
        22: begin inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b1; end
        default: begin
          if (n > 30) begin
            if (resetn && $urandom_range(0, 99) == 0) resetn = 1'b0;
            else if (!resetn && $urandom_range(0, 1) == 1) resetn = 1'b1;
          end
        end
      endcase
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (q_aok[k][r].size() > 0 || q_dok[k][r].size() > 0) begin
          checks++;
          errors++;
          $display("FAIL leftover dut%0d req%0d got pending=%0d expected=0", k, r,
                   q_aok[k][r].size() + q_dok[k][r].size());
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
